// File: rtl/dm_timer_resp.sv
// dm_timer_resp: target side of the dm_* data-memory handshake in front of a 32-bit
// timer/compare peripheral with a level interrupt. Each accepted request is
// completed after WAIT_STATES extra cycles by a one-cycle done pulse.
//
// Register window (offset = dm_addr_i[3:2]):
//   0 CTRL    [0] enable, [1] irq_en, [2] autoreload
//   1 COUNT   free-running counter while enabled
//   2 COMPARE match value
//   3 STATUS  [0] match flag, write-1-to-clear
//
// Ports:
//   clk_i            system clock
//   rst_i            asynchronous active-low reset
//   dm_addr_i        byte address from the CPU
//   dm_data_s_i      store data
//   dm_data_select_i byte enables, bit n covers data[8n+7:8n]
//   dm_store_i       store request
//   dm_load_i        load request
//   dm_data_l_o      load data, held until the next load completes
//   dm_ready_o       high while a new request can be accepted
//   dm_store_done_o  one-cycle store completion pulse
//   dm_load_done_o   one-cycle load completion pulse
//   irq_o            STATUS.flag & CTRL.irq_en, registered

module dm_timer_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h1002_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_ready_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [3:0] WsBits   = WAIT_STATES[3:0];
    localparam bit         HasWait  = (WsBits != 4'd0);
    localparam logic [3:0] WaitLast = HasWait ? (WsBits - 4'd1) : 4'd0;

    localparam logic [1:0] OffCtrl    = 2'd0;
    localparam logic [1:0] OffCount   = 2'd1;
    localparam logic [1:0] OffCompare = 2'd2;
    localparam logic [1:0] OffStatus  = 2'd3;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        is_store_q, is_store_d;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        flag_q, flag_d;
    logic        irq_q, irq_d;

    logic [31:0] data_l_q, data_l_d;
    logic        ready_q, ready_d;
    logic        load_done_q, load_done_d;
    logic        store_done_q, store_done_d;

    logic        addr_hit;
    logic        req_valid;
    logic        enter_done;
    logic        wr_en;
    logic        match;
    logic [31:0] rd_data;

    // Byte lanes below the word offset play no part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^dm_addr_i[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        is_store_d   = is_store_q;
        ctrl_d       = ctrl_q;
        count_d      = count_q;
        compare_d    = compare_q;
        flag_d       = flag_q;
        data_l_d     = data_l_q;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
        rd_data      = 32'd0;

        addr_hit  = (dm_addr_i[31:4] == BASE_ADDR[31:4]);
        req_valid = (dm_load_i | dm_store_i) & addr_hit;

        // Handshake sequencing
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    off_d      = dm_addr_i[3:2];
                    wdata_d    = dm_data_s_i;
                    sel_d      = dm_data_select_i;
                    is_store_d = dm_store_i;  // store wins when both are raised
                    if (HasWait) begin
                        state_d = StWait;
                        wcnt_d  = WaitLast;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWait: begin
                if (wcnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d    = (state_d == StIdle);
        enter_done = (state_d == StDone) && (state_q != StDone);

        // Read mux uses the offset of the transaction entering DONE, so a
        // zero-wait request reads its own register on the capture edge.
        case (off_d)
            OffCtrl:    rd_data = {29'd0, ctrl_q};
            OffCount:   rd_data = count_q;
            OffCompare: rd_data = compare_q;
            default:    rd_data = {31'd0, flag_q};
        endcase

        if (enter_done) begin
            store_done_d = is_store_d;
            load_done_d  = ~is_store_d;
            if (!is_store_d) begin
                data_l_d = rd_data;
            end
        end

        // Timer; a bus write to COUNT overrides increment and reload
        match = ctrl_q[0] && (count_q == compare_q);
        if (ctrl_q[0]) begin
            count_d = (match && ctrl_q[2]) ? 32'd0 : count_q + 32'd1;
        end

        // Stores commit on the edge that leaves DONE
        wr_en = (state_q == StDone) && is_store_q;
        if (wr_en) begin
            case (off_q)
                OffCtrl: begin
                    if (sel_q[0]) begin
                        ctrl_d = wdata_q[2:0];
                    end
                end
                OffCount:   count_d   = merge_bytes(count_q, wdata_q, sel_q);
                OffCompare: compare_d = merge_bytes(compare_q, wdata_q, sel_q);
                default: begin
                    if (sel_q[0] && wdata_q[0]) begin
                        flag_d = 1'b0;
                    end
                end
            endcase
        end

        // A match in the same cycle as a clear leaves the flag set
        if (match) begin
            flag_d = 1'b1;
        end

        irq_d = flag_q & ctrl_q[1];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            wcnt_q       <= 4'd0;
            off_q        <= 2'd0;
            wdata_q      <= 32'd0;
            sel_q        <= 4'd0;
            is_store_q   <= 1'b0;
            ctrl_q       <= 3'd0;
            count_q      <= 32'd0;
            compare_q    <= 32'hFFFF_FFFF;
            flag_q       <= 1'b0;
            irq_q        <= 1'b0;
            data_l_q     <= 32'd0;
            ready_q      <= 1'b1;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            is_store_q   <= is_store_d;
            ctrl_q       <= ctrl_d;
            count_q      <= count_d;
            compare_q    <= compare_d;
            flag_q       <= flag_d;
            irq_q        <= irq_d;
            data_l_q     <= data_l_d;
            ready_q      <= ready_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
        end
    end

    assign dm_data_l_o     = data_l_q;
    assign dm_ready_o      = ready_q;
    assign dm_store_done_o = store_done_q;
    assign dm_load_done_o  = load_done_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_dm_timer_resp.sv
// Bench for dm_timer_resp: a one-wait-state and a zero-wait-state instance share the
// same bus inputs; each is tracked by a transaction-level model (countdown to completion
// plus the register rules) and compared on every falling edge.

module tb_dm_timer_resp;

    localparam logic [31:0] Base = 32'h1002_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a_addr, a_data;
    logic [3:0]  a_sel;
    logic        a_st, a_ld;

    logic [31:0] l1, l0;
    logic        r1, r0, sd1, sd0, ld1, ld0, i1, i0;

    dm_timer_resp #(.BASE_ADDR(Base), .WAIT_STATES(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .dm_addr_i(a_addr), .dm_data_s_i(a_data),
        .dm_data_select_i(a_sel), .dm_store_i(a_st), .dm_load_i(a_ld),
        .dm_data_l_o(l1), .dm_ready_o(r1), .dm_store_done_o(sd1),
        .dm_load_done_o(ld1), .irq_o(i1)
    );

    dm_timer_resp #(.BASE_ADDR(Base), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .dm_addr_i(a_addr), .dm_data_s_i(a_data),
        .dm_data_select_i(a_sel), .dm_store_i(a_st), .dm_load_i(a_ld),
        .dm_data_l_o(l0), .dm_ready_o(r0), .dm_store_done_o(sd0),
        .dm_load_done_o(ld0), .irq_o(i0)
    );

    // Reference model: busy counts the cycles until ready returns; busy==1 is the
    // completion cycle.
    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] count;
        logic [31:0] compare;
        logic        flag;
        logic        irq;
        logic [4:0]  busy;
        logic        t_st;
        logic [1:0]  t_off;
        logic [31:0] t_data;
        logic [3:0]  t_sel;
        logic [31:0] dout;
    } mdl_t;

    typedef struct {
        logic        st;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        hit;
        logic        chkrd;
        logic [31:0] rd;
    } vec_t;

    mdl_t m1, m0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
        return o;
    endfunction

    function automatic logic [31:0] mread(input mdl_t m, input logic [1:0] off);
        case (off)
            2'd0:    return {29'd0, m.ctrl};
            2'd1:    return m.count;
            2'd2:    return m.compare;
            default: return {31'd0, m.flag};
        endcase
    endfunction

    function automatic mdl_t mreset();
        mdl_t n;
        n = '0;
        n.compare = 32'hFFFF_FFFF;
        return n;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int ws);
        mdl_t n;
        logic hit, match, wr;
        n = m;
        hit = ((a_addr >> 4) == (Base >> 4));
        if (m.busy == 5'd0) begin
            if ((a_ld || a_st) && hit) begin
                n.t_st   = a_st;
                n.t_off  = a_addr[3:2];
                n.t_data = a_data;
                n.t_sel  = a_sel;
                n.busy   = 5'(ws + 1);
            end
        end else begin
            n.busy = m.busy - 5'd1;
        end
        wr    = (m.busy == 5'd1) && m.t_st;
        match = m.ctrl[0] && (m.count == m.compare);
        if (m.ctrl[0]) n.count = (match && m.ctrl[2]) ? 32'd0 : m.count + 32'd1;
        if (wr) begin
            case (m.t_off)
                2'd0: if (m.t_sel[0]) n.ctrl = m.t_data[2:0];
                2'd1: n.count = merge(m.count, m.t_data, m.t_sel);
                2'd2: n.compare = merge(m.compare, m.t_data, m.t_sel);
                default: if (m.t_sel[0] && m.t_data[0]) n.flag = 1'b0;
            endcase
        end
        if (match) n.flag = 1'b1;
        n.irq = m.flag & m.ctrl[1];
        if (n.busy == 5'd1 && !n.t_st) n.dout = mread(m, n.t_off);
        return n;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk1("d1.ready", r1, m1.busy == 5'd0);
        chk1("d1.load_done", ld1, (m1.busy == 5'd1) && !m1.t_st);
        chk1("d1.store_done", sd1, (m1.busy == 5'd1) && m1.t_st);
        chk32("d1.data_l", l1, m1.dout);
        chk1("d1.irq", i1, m1.irq);
        chk1("d0.ready", r0, m0.busy == 5'd0);
        chk1("d0.load_done", ld0, (m0.busy == 5'd1) && !m0.t_st);
        chk1("d0.store_done", sd0, (m0.busy == 5'd1) && m0.t_st);
        chk32("d0.data_l", l0, m0.dout);
        chk1("d0.irq", i0, m0.irq);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m1 = mreset();
            m0 = mreset();
        end else begin
            m1 = mstep(m1, 1);
            m0 = mstep(m0, 0);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        a_st = 1'b0;
        a_ld = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        int at1, at0, cnt1, cnt0;
        logic kst1;
        logic [31:0] d1, d0;
        at1 = 0; at0 = 0; cnt1 = 0; cnt0 = 0; kst1 = 1'b0; d1 = '0; d0 = '0;
        a_st = v.st; a_ld = v.ld; a_addr = v.addr; a_data = v.data; a_sel = v.sel;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) idle();
            if (ld1 || sd1) begin
                cnt1++;
                if (at1 == 0) at1 = k;
                kst1 = sd1;
                if (ld1) d1 = l1;
            end
            if (ld0 || sd0) begin
                cnt0++;
                if (at0 == 0) at0 = k;
                if (ld0) d0 = l0;
            end
        end
        chk32("txn d1 done count", 32'(cnt1), v.hit ? 32'd1 : 32'd0);
        chk32("txn d0 done count", 32'(cnt0), v.hit ? 32'd1 : 32'd0);
        if (v.hit) begin
            chk32("txn d1 latency", 32'(at1), 32'd2);
            chk32("txn d0 latency", 32'(at0), 32'd1);
            chk1("txn d1 store kind", kst1, v.st);
            if (v.chkrd && !v.st) begin
                chk32("txn d1 load data", d1, v.rd);
                chk32("txn d0 load data", d0, v.rd);
            end
        end
    endtask

    task automatic txn(input logic st, input logic ld, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel, input logic hit,
                       input logic chkrd, input logic [31:0] rd);
        vec_t v;
        v.st = st; v.ld = ld; v.addr = addr; v.data = data; v.sel = sel;
        v.hit = hit; v.chkrd = chkrd; v.rd = rd;
        do_txn(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [14];
        int   cnt1, cnt0, hold, gap;
        logic seen;

        // {st, ld, addr, data, sel, hit, chkrd, expected read}
        tbl[0]  = '{1'b0, 1'b1, Base + 32'hC, 32'd0,         4'hF, 1'b1, 1'b1, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, Base + 32'h8, 32'h1234_5678, 4'h3, 1'b1, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, Base + 32'h8, 32'd0,         4'hF, 1'b1, 1'b1, 32'hFFFF_5678};
        tbl[3]  = '{1'b0, 1'b1, 32'h1003_0000, 32'd0,        4'hF, 1'b0, 1'b0, 32'd0};
        tbl[4]  = '{1'b1, 1'b0, 32'h1003_0008, 32'd0,        4'hF, 1'b0, 1'b0, 32'd0};
        tbl[5]  = '{1'b0, 1'b1, Base + 32'h8, 32'd0,         4'hF, 1'b1, 1'b1, 32'hFFFF_5678};
        tbl[6]  = '{1'b1, 1'b0, Base + 32'h4, 32'hAABB_CCDD, 4'hF, 1'b1, 1'b0, 32'd0};
        tbl[7]  = '{1'b0, 1'b1, Base + 32'h4, 32'd0,         4'hF, 1'b1, 1'b1, 32'hAABB_CCDD};
        tbl[8]  = '{1'b1, 1'b1, Base + 32'h0, 32'hFFFF_FFFA, 4'h1, 1'b1, 1'b0, 32'd0};
        tbl[9]  = '{1'b0, 1'b1, Base + 32'h0, 32'd0,         4'hF, 1'b1, 1'b1, 32'd2};
        tbl[10] = '{1'b1, 1'b0, Base + 32'hC, 32'd0,         4'hF, 1'b1, 1'b0, 32'd0};
        tbl[11] = '{1'b0, 1'b1, Base + 32'hF, 32'd0,         4'hF, 1'b1, 1'b1, 32'd0};
        tbl[12] = '{1'b1, 1'b0, Base + 32'h4, 32'd0,         4'hF, 1'b1, 1'b0, 32'd0};
        tbl[13] = '{1'b0, 1'b1, Base + 32'h4, 32'd0,         4'hF, 1'b1, 1'b1, 32'd0};

        rst_n = 1'b1;
        a_addr = '0; a_data = '0; a_sel = '0; a_st = 1'b0; a_ld = 1'b0;
        m1 = mreset();
        m0 = mreset();
        #2 rst_n = 1'b0;
        #1 check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) do_txn(tbl[i]);

        // Timer with autoreload at COMPARE=10 and interrupt enabled
        txn(1'b1, 1'b0, Base + 32'h8, 32'd10, 4'hF, 1'b1, 1'b0, 32'd0);
        txn(1'b1, 1'b0, Base + 32'h0, 32'd7, 4'h1, 1'b1, 1'b0, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (i1) seen = 1'b1;
        end
        chk1("irq rise", seen, 1'b1);
        txn(1'b1, 1'b0, Base + 32'h0, 32'd2, 4'h1, 1'b1, 1'b0, 32'd0);
        txn(1'b1, 1'b0, Base + 32'hC, 32'd1, 4'h1, 1'b1, 1'b0, 32'd0);
        tick();
        tick();
        chk1("irq clear d1", i1, 1'b0);
        chk1("irq clear d0", i0, 1'b0);
        txn(1'b0, 1'b1, Base + 32'h4, 32'd0, 4'hF, 1'b1, 1'b0, 32'd0);
        chk1("count within reload range", l1 <= 32'd10, 1'b1);

        // Second request during the wait state is ignored
        cnt1 = 0; cnt0 = 0;
        a_ld = 1'b1; a_addr = Base + 32'hC;
        tick();
        cnt1 += int'(ld1); cnt0 += int'(ld0);
        a_addr = Base + 32'h8;
        tick();
        cnt1 += int'(ld1); cnt0 += int'(ld0);
        idle();
        repeat (5) begin
            tick();
            cnt1 += int'(ld1); cnt0 += int'(ld0);
        end
        chk32("busy request d1 pulses", 32'(cnt1), 32'd1);
        chk32("busy request d0 pulses", 32'(cnt0), 32'd1);

        // Zero-wait back-to-back store then load
        a_st = 1'b1; a_addr = Base + 32'h8; a_data = 32'h0000_0055; a_sel = 4'h1;
        tick();
        chk1("b2b store done", sd0, 1'b1);
        idle();
        tick();
        chk1("b2b ready", r0, 1'b1);
        a_ld = 1'b1; a_addr = Base + 32'h8;
        tick();
        chk1("b2b load done", ld0, 1'b1);
        chk32("b2b load data", l0, 32'h0000_0055);
        idle();
        tick();
        tick();

        // Bus write to COUNT while counting
        txn(1'b1, 1'b0, Base + 32'h0, 32'd1, 4'h1, 1'b1, 1'b0, 32'd0);
        a_st = 1'b1; a_addr = Base + 32'h4; a_data = 32'd5; a_sel = 4'hF;
        tick();
        idle();
        repeat (4) tick();
        a_ld = 1'b1; a_addr = Base + 32'h4;
        tick();
        chk1("count write d0 done", ld0, 1'b1);
        chk32("count write d0 data", l0, 32'd8);
        idle();
        tick();
        chk1("count write d1 done", ld1, 1'b1);
        chk32("count write d1 data", l1, 32'd8);
        tick();
        txn(1'b1, 1'b0, Base + 32'h0, 32'd0, 4'h1, 1'b1, 1'b0, 32'd0);

        // Reset during the wait state aborts the transaction
        a_ld = 1'b1; a_addr = Base + 32'h8;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        m1 = mreset();
        m0 = mreset();
        check_all();
        tick();
        rst_n = 1'b1;
        cnt1 = 0;
        repeat (3) begin
            tick();
            cnt1 += int'(ld1) + int'(sd1);
        end
        chk32("reset abort pulses", 32'(cnt1), 32'd0);
        chk1("reset abort ready", r1, 1'b1);
        txn(1'b0, 1'b1, Base + 32'h8, 32'd0, 4'hF, 1'b1, 1'b1, 32'hFFFF_FFFF);
        txn(1'b0, 1'b1, Base + 32'h0, 32'd0, 4'hF, 1'b1, 1'b1, 32'd0);

        // Random traffic against the model
        for (int it = 0; it < 300; it++) begin
            a_st = 1'($urandom_range(0, 1));
            a_ld = !a_st || ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 6) == 0) a_addr = 32'h1003_0000 | ($urandom & 32'hF);
            else a_addr = Base | ($urandom & 32'hF);
            a_data = $urandom;
            a_sel = 4'($urandom);
            hold = $urandom_range(1, 3);
            repeat (hold) tick();
            idle();
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
        end
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
